// File: rtl/pa_riscv.sv
// ============================================================================
// Module      : pa_riscv
// Description : RV32I opcode constants and the opcode-to-format mapping
//               shared by the controller decode and the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pa_riscv;

  localparam logic [6:0] LW         = 7'b0000011;
  localparam logic [6:0] SW         = 7'b0100011;
  localparam logic [6:0] R_TYPE_ALU = 7'b0110011;
  localparam logic [6:0] B_TYPE     = 7'b1100011;
  localparam logic [6:0] I_TYPE_ALU = 7'b0010011;

  typedef enum logic [2:0] {
    R_FMT   = 3'd0,
    I_FMT   = 3'd1,
    S_FMT   = 3'd2,
    B_FMT   = 3'd3,
    BAD_FMT = 3'd4
  } e_instr_format;

  function automatic e_instr_format operand_to_format(input logic [6:0] operand);
    e_instr_format fmt;
    case (operand)
      R_TYPE_ALU:     fmt = R_FMT;
      LW, I_TYPE_ALU: fmt = I_FMT;
      SW:             fmt = S_FMT;
      B_TYPE:         fmt = B_FMT;
      default:        fmt = BAD_FMT;
    endcase
    return fmt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync.sv
// ============================================================================
// Module      : fifo_sync
// Description : Single-clock FIFO with synchronous reset and clear; the head
//               word reads as zero while the FIFO is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_sync #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             w_do_push, w_do_pop;

  assign o_full    = (count_q == C_DEPTH);
  assign o_empty   = (count_q == '0);
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty && !i_clear;
  assign o_data    = o_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // simultaneous push and pop leaves occupancy unchanged
      case ({w_do_push, w_do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Encodes decoded RV32I field bundles into machine words,
//               buffers them and writes them to sequential imem addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader
  import pa_riscv::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [6:0]        i_operand,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic              i_funct7bit5,
  input  logic [31:0]       i_imm,
  output logic              o_illegal,
  output logic              o_imemWriteEn,
  input  logic              i_imemReady,
  output logic [ADDR_W-1:0] o_imemAddr,
  output logic [31:0]       o_imemWriteData,
  output logic              o_wrapped
);

  e_instr_format     w_fmt;
  logic [31:0]       w_word;
  logic              w_accept, w_push, w_pop;
  logic              w_full, w_empty;
  logic              w_is_shift;
  logic              w_unused_imm;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wrapped_q, wrapped_d;
  logic              illegal_q, illegal_d;

  // no path from i_imemReady: a pop this cycle only frees space next cycle
  assign o_ready       = !w_full && !i_rst;
  assign w_accept      = i_valid && o_ready;
  assign w_fmt         = operand_to_format(i_operand);
  assign w_push        = w_accept && (w_fmt != BAD_FMT) && !i_clear;
  assign o_imemWriteEn = !w_empty;
  assign w_pop         = o_imemWriteEn && i_imemReady && !i_clear;
  assign w_is_shift    = (i_operand == I_TYPE_ALU) &&
                         ((i_funct3 == 3'b001) || (i_funct3 == 3'b101));
  assign w_unused_imm  = ^i_imm[31:13];

  always_comb begin
    w_word = '0;
    case (w_fmt)
      R_FMT:
        w_word = {1'b0, i_funct7bit5, 5'b00000, i_rs2, i_rs1, i_funct3, i_rd, i_operand};
      I_FMT:
        if (w_is_shift)
          w_word = {1'b0, i_funct7bit5, 5'b00000, i_imm[4:0], i_rs1, i_funct3, i_rd, i_operand};
        else
          w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_operand};
      S_FMT:
        w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_operand};
      B_FMT:
        w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_operand};
      default:
        w_word = '0;
    endcase
  end

  fifo_sync #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (o_imemWriteData),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    addr_d    = addr_q;
    wrapped_d = wrapped_q;
    illegal_d = w_accept && (w_fmt == BAD_FMT) && !i_clear;
    if (i_clear) begin
      addr_d    = BASE_ADDR;
      wrapped_d = 1'b0;
    end else if (w_pop) begin
      // rolling past all-ones lands on 0, not BASE_ADDR
      addr_d = addr_q + ADDR_W'(1);
      if (&addr_q) wrapped_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q    <= BASE_ADDR;
      wrapped_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wrapped_q <= wrapped_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_imemAddr = addr_q;
  assign o_wrapped  = wrapped_q;
  assign o_illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader; a default instance
//               and a 2-bit-address instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_clear = 1'b0, i_valid = 1'b0, i_imemReady = 1'b1;
  logic [6:0]  i_operand = '0;
  logic [4:0]  i_rd = '0, i_rs1 = '0, i_rs2 = '0;
  logic [2:0]  i_funct3 = '0;
  logic        i_funct7bit5 = 1'b0;
  logic [31:0] i_imm = '0;

  logic        a_ready, a_illegal, a_we, a_wrapped;
  logic [7:0]  a_addr;
  logic [31:0] a_data;
  logic        b_ready, b_illegal, b_we, b_wrapped;
  logic [1:0]  b_addr;
  logic [31:0] b_data;

  int   n_checks = 0;
  int   n_pass = 0;
  bit   mon_a = 1'b0, mon_b = 1'b0, sel_b = 1'b0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [7:0] next_a = '0;
  logic [1:0] next_b = '0;
  vec_t vecs[7];
  vec_t ill;

  always #5 clk = ~clk;

  program_loader dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(a_ready),
    .i_operand(i_operand), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_funct3(i_funct3),
    .i_funct7bit5(i_funct7bit5), .i_imm(i_imm), .o_illegal(a_illegal), .o_imemWriteEn(a_we),
    .i_imemReady(i_imemReady), .o_imemAddr(a_addr), .o_imemWriteData(a_data), .o_wrapped(a_wrapped)
  );

  program_loader #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(2'd0)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(b_ready),
    .i_operand(i_operand), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_funct3(i_funct3),
    .i_funct7bit5(i_funct7bit5), .i_imm(i_imm), .o_illegal(b_illegal), .o_imemWriteEn(b_we),
    .i_imemReady(i_imemReady), .o_imemAddr(b_addr), .o_imemWriteData(b_data), .o_wrapped(b_wrapped)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_ready();
    return sel_b ? b_ready : a_ready;
  endfunction

  function automatic logic cur_we();
    return sel_b ? b_we : a_we;
  endfunction

  task automatic set_fields(input vec_t v);
    i_operand    = v.op;
    i_rd         = v.rd;
    i_rs1        = v.rs1;
    i_rs2        = v.rs2;
    i_funct3     = v.f3;
    i_funct7bit5 = v.f7;
    i_imm        = v.imm;
  endtask

  // offers a bundle, waits for acceptance, and records the expected write
  task automatic send(input vec_t v);
    int waited = 0;
    set_fields(v);
    i_valid = 1'b1;
    while (!cur_ready()) begin
      tick();
      waited++;
      if (waited > 50) begin
        check("accept timeout", 32'd0, 32'd1);
        i_valid = 1'b0;
        return;
      end
    end
    if (v.legal) begin
      if (sel_b) begin
        qb.push_back('{addr: {6'd0, next_b}, data: v.word});
        next_b = next_b + 2'd1;
      end else begin
        qa.push_back('{addr: next_a, data: v.word});
        next_a = next_a + 8'd1;
      end
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (cur_we() && n < 40) begin
      tick();
      n++;
    end
    check("drain completes", {31'd0, cur_we()}, 32'd0);
    check("scoreboard empty", sel_b ? qb.size() : qa.size(), 32'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_clear = 1'b0;
    tick();
    tick();
    check("ready low in reset", {31'd0, a_ready}, 32'd0);
    i_rst = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    next_a = '0;
    next_b = '0;
  endtask

  always @(negedge clk) begin
    if (mon_a && !i_rst && !i_clear && a_we && i_imemReady) begin
      if (qa.size() == 0) check("unexpected write A", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        check("write addr A", {24'd0, a_addr}, {24'd0, ea.addr});
        check("write data A", a_data, ea.data);
      end
    end
    if (mon_b && !i_rst && !i_clear && b_we && i_imemReady) begin
      if (qb.size() == 0) check("unexpected write B", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        check("write addr B", {30'd0, b_addr}, {24'd0, eb.addr});
        check("write data B", b_data, eb.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op     rd  rs1 rs2 f3  f7  imm           legal word
    vecs[0] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 32'h0020_81B3};
    vecs[1] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'h0000_0000, 1'b1, 32'h4020_81B3};
    vecs[2] = '{7'h03, 5'd5, 5'd2, 5'd9, 3'd2, 1'b0, 32'h0000_0008, 1'b1, 32'h0081_2283};
    vecs[3] = '{7'h23, 5'd31, 5'd2, 5'd6, 3'd2, 1'b0, 32'h0000_000C, 1'b1, 32'h0061_2623};
    vecs[4] = '{7'h63, 5'd7, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3};
    vecs[5] = '{7'h13, 5'd4, 5'd1, 5'd0, 3'd5, 1'b1, 32'h0000_0FE3, 1'b1, 32'h4030_D213};
    vecs[6] = '{7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0393};
    ill     = '{7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};

    do_reset();
    check("reset ready", {31'd0, a_ready}, 32'd1);
    check("reset we", {31'd0, a_we}, 32'd0);
    check("reset addr", {24'd0, a_addr}, 32'd0);
    check("reset data", a_data, 32'd0);
    check("reset illegal", {31'd0, a_illegal}, 32'd0);
    check("reset wrapped", {31'd0, a_wrapped}, 32'd0);
    mon_a = 1'b1;

    send(vecs[0]);
    check("we cycle after accept", {31'd0, a_we}, 32'd1);
    drain();
    for (int i = 1; i < 7; i++) send(vecs[i]);
    drain();
    check("data zero when empty", a_data, 32'd0);

    send(ill);
    check("illegal pulse", {31'd0, a_illegal}, 32'd1);
    check("illegal no write", {31'd0, a_we}, 32'd0);
    tick();
    check("illegal one cycle", {31'd0, a_illegal}, 32'd0);
    check("illegal addr unchanged", {24'd0, a_addr}, 32'd7);

    // stall: four words fill the FIFO, the fifth is held off
    do_reset();
    i_imemReady = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[i]);
    set_fields(vecs[4]);
    i_valid = 1'b1;
    check("ready low when full", {31'd0, a_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall we", {31'd0, a_we}, 32'd1);
      check("stall addr", {24'd0, a_addr}, 32'd0);
      check("stall data", a_data, vecs[0].word);
      tick();
    end
    i_imemReady = 1'b1;
    send(vecs[4]);
    drain();
    check("addr after five", {24'd0, a_addr}, 32'd5);

    // wrap-around on the 2-bit-address instance
    do_reset();
    mon_a = 1'b0;
    sel_b = 1'b1;
    mon_b = 1'b1;
    for (int i = 0; i < 3; i++) send(vecs[i]);
    drain();
    check("not wrapped yet", {31'd0, b_wrapped}, 32'd0);
    check("addr before wrap", {30'd0, b_addr}, 32'd3);
    send(vecs[3]);
    drain();
    check("wrapped after 4th", {31'd0, b_wrapped}, 32'd1);
    check("addr wraps to 0", {30'd0, b_addr}, 32'd0);
    send(vecs[4]);
    drain();
    check("wrapped sticky", {31'd0, b_wrapped}, 32'd1);
    check("addr after wrap", {30'd0, b_addr}, 32'd1);

    // clear while stalled with two words buffered; same-cycle accept and write dropped
    i_imemReady = 1'b0;
    send(vecs[5]);
    send(vecs[6]);
    check("buffered before clear", {31'd0, b_we}, 32'd1);
    set_fields(vecs[0]);
    i_valid = 1'b1;
    i_imemReady = 1'b1;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    i_valid = 1'b0;
    qb.delete();
    next_b = 2'd0;
    check("clear empties", {31'd0, b_we}, 32'd0);
    check("clear addr", {30'd0, b_addr}, 32'd0);
    check("clear wrapped", {31'd0, b_wrapped}, 32'd0);
    check("clear ready", {31'd0, b_ready}, 32'd1);
    check("clear data", b_data, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("no write after clear", {31'd0, b_we}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Encoder-side counterpart to the single-cycle controller's decode.
- Accepts decoded instruction fields (opcode, registers, funct3, funct7 bit 5, immediate) over a valid/ready handshake.
- Assembles each into an RV32I machine word (R/I/S/B formats), buffers it in a small FIFO, and writes words sequentially into instruction memory from a running word address.
- Used by the bench and boot path to load programs the core then fetches and decodes.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address after reset or clear

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_clear  input  1  flush FIFO, reload address to BASE_ADDR, clear o_wrapped
- i_valid  input  1  field bundle valid
- o_ready  output  1  encoder can accept a bundle
- i_operand  input  7  opcode (LW, SW, R_TYPE_ALU, B_TYPE, I_TYPE_ALU)
- i_rd  input  5  destination register
- i_rs1  input  5  source register 1
- i_rs2  input  5  source register 2
- i_funct3  input  3  funct3
- i_funct7bit5  input  1  funct7[5] (SUB/SRA/SRAI)
- i_imm  input  32  immediate; bits used per format
- o_illegal  output  1  one-cycle pulse: accepted bundle had unsupported opcode
- o_imemWriteEn  output  1  write request to instruction memory
- i_imemReady  input  1  memory accepts write this cycle
- o_imemAddr  output  ADDR_W  word address of current write
- o_imemWriteData  output  32  encoded instruction word
- o_wrapped  output  1  sticky: address counter wrapped past all-ones

Behaviour:
- Clock is i_clk; reset is i_rst, synchronous active-high.
- Reset values:
  - o_ready=0 while i_rst is high, 1 the first cycle after.
  - o_imemWriteEn=0, o_imemAddr=BASE_ADDR, o_imemWriteData=0.
  - o_illegal=0, o_wrapped=0, FIFO empty.
- Handshake and FIFO:
  - Accept when i_valid && o_ready; fields are sampled that edge.
  - o_ready = !full. A pop in the same cycle does not raise o_ready (no combinational path from i_imemReady).
  - Push and pop in the same cycle keep occupancy unchanged.
- Encoding, combinational before the FIFO:
  - R: {0,f7b5,00000, rs2, rs1, funct3, rd, opcode}
  - I (LW, I_TYPE_ALU): {imm[11:0], rs1, funct3, rd, opcode}. Exception: I_TYPE_ALU with funct3 001/101 uses imm[11:5] = {0,f7b5,00000}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; imm[0] is ignored.
  - Unused fields for a format are ignored.
- Illegal opcode:
  - The handshake still completes.
  - Nothing is pushed.
  - o_illegal=1 the cycle after accept.
- Latency: a bundle accepted into an empty FIFO at edge N gives o_imemWriteEn=1 from cycle N+1.
- Write side:
  - o_imemWriteEn = !empty; o_imemWriteData = FIFO head, or 0 when empty.
  - The write completes on an edge with o_imemWriteEn && i_imemReady. Then pop and increment o_imemAddr.
  - Address, data and enable stay stable while i_imemReady=0.
- Wrap-around:
  - A completed write at address 2^ADDR_W-1 sets the next address to 0 (not BASE_ADDR).
  - It also sets o_wrapped, which stays set until i_clear or i_rst.
- i_clear (one cycle):
  - Priority over push and pop. The same-cycle accept and write are discarded.
  - Next cycle: FIFO empty, o_imemAddr=BASE_ADDR, o_wrapped=0, o_ready=1.
- Reset mid-operation: identical to the reset state next cycle; buffered words are lost.

Decomposition:
- pa_riscv holds:
  - The existing opcode constants.
  - New typedef e_instr_format {R_FMT, I_FMT, S_FMT, B_FMT, BAD_FMT}.
  - Function operand_to_format.
- One sub-module: fifo_sync (DEPTH, width 32; push/pop/full/empty; synchronous reset and clear).

Test Plan:
- add x3,x1,x2 (R, f3=0, f7b5=0), i_imemReady=1 -> one write at addr 0, data 0x002081B3, enable high the cycle after accept.
- sub x3,x1,x2 (f7b5=1), then lw x5,8(x2) (f3=2) -> writes 0x402081B3 @0, 0x00812283 @1.
- sw x6,12(x2) (f3=2), then beq x1,x2,imm=-4 (i_imm=0xFFFFFFFC) -> 0x00612623, then 0xFE208EE3 at consecutive addresses.
- i_imemReady=0, offer 5 bundles:
  - o_ready drops after the 4th accept; the 5th is held.
  - Address and data stay stable while stalled.
  - On release: 5 writes at addrs 0..4 in order, no loss or duplication.
- i_operand=0x7F accepted -> o_illegal pulses 1 cycle, no write, address unchanged.
- ADDR_W=2, 5 writes -> addresses 0,1,2,3,0 and o_wrapped set after the 4th write. Then i_clear asserted mid-stall with 2 words buffered -> next cycle FIFO empty, addr=BASE_ADDR, o_wrapped=0, no further writes.
